// File: rtl/poli_ctrl_regs_if.sv
// Register-access bus between the POLI APB slave and the control register file.
// The slave side consumes one write per strobe and returns the selected register.
interface poli_ctrl_regs_if #(
    parameter int WORD_SIZE = 32
) ();
    logic [WORD_SIZE-1:0] write_data;
    logic                 write_enable;
    logic [2:0]           register_select;
    logic [WORD_SIZE-1:0] read_data;

    modport master (
        output write_data,
        output write_enable,
        output register_select,
        input  read_data
    );

    modport slave (
        input  write_data,
        input  write_enable,
        input  register_select,
        output read_data
    );
endinterface

// File: rtl/poli_ctrl_regs.sv
// POLI control/status register file and job sequencer: holds job configuration,
// launches the core with a one-cycle start pulse, tracks busy/done/errors, counts cycles.
module poli_ctrl_regs #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    poli_ctrl_regs_if.slave      bus,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic                 core_error,
    output logic [WORD_SIZE-1:0] cfg_src,
    output logic [WORD_SIZE-1:0] cfg_dst,
    output logic [WORD_SIZE-1:0] cfg_len,
    output logic                 irq
);
    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_STATUS   = 3'd1;
    localparam logic [2:0] SEL_SRC_ADDR = 3'd2;
    localparam logic [2:0] SEL_DST_ADDR = 3'd3;
    localparam logic [2:0] SEL_LENGTH   = 3'd4;
    localparam logic [2:0] SEL_CYCLES   = 3'd5;

    localparam logic [WORD_SIZE-1:0] WORD_ONE  = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] WORD_ONES = {WORD_SIZE{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WORD_SIZE-1:0] src_r;
    logic [WORD_SIZE-1:0] dst_r;
    logic [WORD_SIZE-1:0] len_r;
    logic [WORD_SIZE-1:0] cycles_r;
    logic                 irq_en_r;
    logic                 done_r;
    logic                 core_err_r;
    logic                 cmd_err_r;

    logic busy_s;
    logic wr_ctrl_s;
    logic wr_status_s;
    logic wr_cfg_s;
    logic start_req_s;
    logic start_ok_s;
    logic done_set_s;
    logic core_err_set_s;
    logic cmd_err_set_s;

    assign busy_s         = (state_r != ST_IDLE);
    assign wr_ctrl_s      = bus.write_enable && (bus.register_select == SEL_CTRL);
    assign wr_status_s    = bus.write_enable && (bus.register_select == SEL_STATUS);
    assign wr_cfg_s       = bus.write_enable && ((bus.register_select == SEL_SRC_ADDR) ||
                                                 (bus.register_select == SEL_DST_ADDR) ||
                                                 (bus.register_select == SEL_LENGTH));
    assign start_req_s    = wr_ctrl_s && bus.write_data[0];
    assign start_ok_s     = start_req_s && !busy_s && (len_r != '0);
    // Core pulses only count while a job is running; strays in IDLE are ignored.
    assign done_set_s     = core_done && (state_r == ST_RUN);
    assign core_err_set_s = core_error && (state_r == ST_RUN);
    assign cmd_err_set_s  = (start_req_s && !start_ok_s) || (wr_cfg_s && busy_s);

    // Job sequencer state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job sequencer next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (core_done || core_error) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Configuration and interrupt-enable registers; configuration is frozen while busy.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            irq_en_r <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                irq_en_r <= bus.write_data[1];
            end
            if (bus.write_enable && !busy_s) begin
                case (bus.register_select)
                    SEL_SRC_ADDR: src_r <= bus.write_data;
                    SEL_DST_ADDR: dst_r <= bus.write_data;
                    SEL_LENGTH:   len_r <= bus.write_data;
                    default:      ;
                endcase
            end
        end
    end

    // Sticky status bits: W1C, with a same-cycle set taking priority over the clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done_r     <= 1'b0;
            core_err_r <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            done_r     <= done_set_s     | (done_r     & ~(wr_status_s & bus.write_data[1]));
            core_err_r <= core_err_set_s | (core_err_r & ~(wr_status_s & bus.write_data[2]));
            cmd_err_r  <= cmd_err_set_s  | (cmd_err_r  & ~(wr_status_s & bus.write_data[3]));
        end
    end

    // Job cycle counter, cleared on start acceptance and saturating at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycles_r <= '0;
        end else if (start_ok_s) begin
            cycles_r <= '0;
        end else if (busy_s && (cycles_r != WORD_ONES)) begin
            cycles_r <= cycles_r + WORD_ONE;
        end
    end

    // Register read mux; unmapped selects read as zero.
    always_comb begin
        bus.read_data = '0;
        case (bus.register_select)
            SEL_CTRL:     bus.read_data = {{(WORD_SIZE-2){1'b0}}, irq_en_r, 1'b0};
            SEL_STATUS:   bus.read_data = {{(WORD_SIZE-4){1'b0}}, cmd_err_r, core_err_r, done_r, busy_s};
            SEL_SRC_ADDR: bus.read_data = src_r;
            SEL_DST_ADDR: bus.read_data = dst_r;
            SEL_LENGTH:   bus.read_data = len_r;
            SEL_CYCLES:   bus.read_data = cycles_r;
            default:      bus.read_data = '0;
        endcase
    end

    assign core_start = (state_r == ST_START);
    assign cfg_src    = src_r;
    assign cfg_dst    = dst_r;
    assign cfg_len    = len_r;
    assign irq        = irq_en_r & (done_r | core_err_r | cmd_err_r);
endmodule

// File: tb/tb_poli_ctrl_regs.sv
// Self-checking bench for poli_ctrl_regs: per-scenario tasks, expected register
// reads queued when stimulus is driven and popped when the read is sampled.
module tb_poli_ctrl_regs;
    localparam int W = 32;
    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_STATUS = 3'd1;
    localparam logic [2:0] R_SRC    = 3'd2;
    localparam logic [2:0] R_DST    = 3'd3;
    localparam logic [2:0] R_LEN    = 3'd4;
    localparam logic [2:0] R_CYCLES = 3'd5;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         core_done = 1'b0;
    logic         core_error = 1'b0;
    logic         core_start;
    logic         irq;
    logic [W-1:0] cfg_src;
    logic [W-1:0] cfg_dst;
    logic [W-1:0] cfg_len;

    int           checks = 0;
    int           errors = 0;
    int           start_cnt = 0;
    int           base;
    logic [31:0]  exp_q[$];
    logic [31:0]  got;
    logic [31:0]  exp;

    poli_ctrl_regs_if #(.WORD_SIZE(W)) bus ();

    poli_ctrl_regs #(.WORD_SIZE(W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .core_start (core_start),
        .core_done  (core_done),
        .core_error (core_error),
        .cfg_src    (cfg_src),
        .cfg_dst    (cfg_dst),
        .cfg_len    (cfg_len),
        .irq        (irq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (core_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        @(posedge CLK);
        #1;
        bus.write_enable    = 1'b1;
        bus.register_select = sel;
        bus.write_data      = d;
        @(posedge CLK);
        #1;
        bus.write_enable    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] v);
        bus.register_select = sel;
        @(negedge CLK);
        v = bus.read_data;
    endtask

    task automatic test_reset();
        bus.write_enable = 1'b0;
        bus.write_data = 32'h0;
        bus.register_select = R_CTRL;
        nRST = 1'b0;
        tick(3);
        nRST = 1'b1;
        for (int s = 0; s < 8; s++) exp_q.push_back(32'h0);
        for (int s = 0; s < 8; s++) begin
            rd(3'(s), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_read sel=%0d: got %h expected %h", s, got, exp); end
        end
        checks++;
        if ({core_start, irq} !== 2'b00) begin errors++; $display("FAIL reset_outputs: core_start/irq %b expected 00", {core_start, irq}); end
        checks++;
        if ({cfg_src, cfg_dst, cfg_len} !== 96'h0) begin errors++; $display("FAIL reset_cfg: got %h expected 0", {cfg_src, cfg_dst, cfg_len}); end
    endtask

    task automatic test_config_run();
        base = start_cnt;
        wr(R_SRC, 32'h0000_1000);
        wr(R_DST, 32'h0000_2000);
        wr(R_LEN, 32'd16);
        wr(R_CTRL, 32'h3);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_status_start: got %h expected %h", got, exp); end
        checks++;
        if (core_start !== 1'b1) begin errors++; $display("FAIL run_core_start_high: got %b expected 1", core_start); end
        tick(1);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_status_busy: got %h expected %h", got, exp); end
        checks++;
        if (core_start !== 1'b0) begin errors++; $display("FAIL run_core_start_low: got %b expected 0", core_start); end
        checks++;
        if ({cfg_src, cfg_dst, cfg_len} !== {32'h1000, 32'h2000, 32'd16}) begin errors++; $display("FAIL run_cfg: got %h expected 00001000_00002000_00000010", {cfg_src, cfg_dst, cfg_len}); end
        tick(4);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        exp_q.push_back(32'h2);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'h2);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_status_done: got %h expected %h", got, exp); end
        rd(R_CYCLES, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_cycles: got %0d expected %0d", got, exp); end
        rd(R_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_ctrl_readback: got %h expected %h", got, exp); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL run_irq_set: got %b expected 1", irq); end
        checks++;
        if (start_cnt !== base + 1) begin errors++; $display("FAIL run_start_pulses: got %0d expected %0d", start_cnt - base, 1); end
        wr(R_STATUS, 32'h2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL run_irq_clear: got %b expected 0", irq); end
        exp_q.push_back(32'h0);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_status_cleared: got %h expected %h", got, exp); end
    endtask

    task automatic test_rejections();
        base = start_cnt;
        wr(R_LEN, 32'd0);
        wr(R_CTRL, 32'h3);
        tick(2);
        checks++;
        if (start_cnt !== base) begin errors++; $display("FAIL rej_len0_pulse: got %0d pulses expected 0", start_cnt - base); end
        exp_q.push_back(32'h8);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rej_len0_status: got %h expected %h", got, exp); end
        wr(R_STATUS, 32'h8);
        wr(R_LEN, 32'd16);
        wr(R_CTRL, 32'h3);
        wr(R_CTRL, 32'h3);
        wr(R_LEN, 32'd5);
        exp_q.push_back(32'h9);
        exp_q.push_back(32'd16);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rej_busy_status: got %h expected %h", got, exp); end
        rd(R_LEN, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rej_len_busy: got %0d expected %0d", got, exp); end
        checks++;
        if (start_cnt !== base + 1) begin errors++; $display("FAIL rej_busy_pulses: got %0d expected 1", start_cnt - base); end
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        exp_q.push_back(32'hA);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rej_job_end: got %h expected %h", got, exp); end
        wr(R_STATUS, 32'hE);
    endtask

    task automatic test_error_path();
        wr(R_CTRL, 32'h3);
        tick(2);
        core_error = 1'b1;
        tick(1);
        core_error = 1'b0;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL err_status: got %h expected %h", got, exp); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL err_irq: got %b expected 1", irq); end
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL err_idle_done_ignored: got %h expected %h", got, exp); end
        wr(R_STATUS, 32'h4);
    endtask

    task automatic test_w1c_race();
        wr(R_CTRL, 32'h3);
        tick(2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        wr(R_CTRL, 32'h3);
        exp_q.push_back(32'h3);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL race_done_kept_on_start: got %h expected %h", got, exp); end
        tick(1);
        bus.write_enable    = 1'b1;
        bus.register_select = R_STATUS;
        bus.write_data      = 32'h2;
        core_done           = 1'b1;
        tick(1);
        bus.write_enable    = 1'b0;
        core_done           = 1'b0;
        exp_q.push_back(32'h2);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL race_set_wins: got %h expected %h", got, exp); end
        wr(R_STATUS, 32'h2);
        exp_q.push_back(32'h0);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL race_plain_clear: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid_run();
        wr(R_SRC, 32'hAAAA_0000);
        wr(R_CTRL, 32'h3);
        tick(2);
        nRST = 1'b0;
        #1;
        checks++;
        if ({core_start, irq} !== 2'b00) begin errors++; $display("FAIL rst_run_outputs: core_start/irq %b expected 00", {core_start, irq}); end
        checks++;
        if ({cfg_src, cfg_len} !== 64'h0) begin errors++; $display("FAIL rst_run_cfg: got %h expected 0", {cfg_src, cfg_len}); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_run_status: got %h expected %h", got, exp); end
        rd(R_CYCLES, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_run_cycles: got %h expected %h", got, exp); end
        tick(1);
        nRST = 1'b1;
        base = start_cnt;
        wr(R_LEN, 32'd8);
        wr(R_CTRL, 32'h1);
        checks++;
        if (core_start !== 1'b1) begin errors++; $display("FAIL rst_restart_pulse: got %b expected 1", core_start); end
        tick(3);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        exp_q.push_back(32'd4);
        exp_q.push_back(32'h2);
        rd(R_CYCLES, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_restart_cycles: got %0d expected %0d", got, exp); end
        rd(R_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_restart_status: got %h expected %h", got, exp); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_disabled: got %b expected 0", irq); end
        checks++;
        if (start_cnt !== base + 1) begin errors++; $display("FAIL rst_restart_pulses: got %0d expected 1", start_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_config_run();
        test_rejections();
        test_error_path();
        test_w1c_race();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
